// File: rtl/accel_mem_pkg.sv
// Shared definitions for the accelerator memory arbiter: op codes, FSM encoding, defaults.
// Latency: n/a (definitions only).
// Backpressure: n/a.
package accel_mem_pkg;

    localparam logic [1:0] MEM_OP_NONE  = 2'b00;
    localparam logic [1:0] MEM_OP_READ  = 2'b01;
    localparam logic [1:0] MEM_OP_WRITE = 2'b11;

    localparam logic [31:0] TIMEOUT_DATA_DEFAULT = 32'hDEAD_BEEF;

    // Requester index width; sized for the largest supported engine array (8).
    localparam int IDX_W = 3;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        WAIT = 2'b01,
        RESP = 2'b10
    } arb_state_t;

    // 2'b10 is not a legal operation and must not be granted.
    function automatic logic is_request(input logic [1:0] op);
        return (op == MEM_OP_READ) || (op == MEM_OP_WRITE);
    endfunction

endpackage

// File: rtl/accel_mem_arbiter_if.sv
// Bundle of the engine-side request/response bus, the shared memory port and arbiter status.
// Latency: n/a (wires only).
// Backpressure: engines hold addr/op until their req_opdone_o pulse; memory answers with mem_opdone_i.
// Ports: req_* (engines), mem_* (memory), grant/busy/timeout status. slave = arbiter, master = surroundings.
interface accel_mem_arbiter_if #(
    parameter int N_REQ = 4
);
    logic [2*N_REQ-1:0]  req_operation_i;
    logic [32*N_REQ-1:0] req_addr_i;
    logic [32*N_REQ-1:0] req_wdata_i;
    logic [N_REQ-1:0]    req_opdone_o;
    logic [31:0]         req_rdata_o;
    logic [N_REQ-1:0]    grant_o;
    logic [1:0]          mem_operation_o;
    logic [31:0]         mem_addr_o;
    logic [31:0]         mem_data_o;
    logic                mem_opdone_i;
    logic [31:0]         mem_data_i;
    logic                busy_o;
    logic                timeout_err_o;
    logic [2:0]          timeout_id_o;

    modport slave (
        input  req_operation_i, req_addr_i, req_wdata_i, mem_opdone_i, mem_data_i,
        output req_opdone_o, req_rdata_o, grant_o, mem_operation_o, mem_addr_o,
               mem_data_o, busy_o, timeout_err_o, timeout_id_o
    );

    modport master (
        output req_operation_i, req_addr_i, req_wdata_i, mem_opdone_i, mem_data_i,
        input  req_opdone_o, req_rdata_o, grant_o, mem_operation_o, mem_addr_o,
               mem_data_o, busy_o, timeout_err_o, timeout_id_o
    );

endinterface

// File: rtl/rr_pick.sv
// Round-robin selector: first active request strictly after ptr, wrapping around.
// Latency: combinational.
// Backpressure: none; caller decides when the pick is consumed.
// Ports: req (request vector), ptr (last winner) -> gnt (one-hot), vld, idx (binary winner).
module rr_pick
    import accel_mem_pkg::*;
#(
    parameter int N_REQ = 4
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IDX_W-1:0] ptr,
    output logic [N_REQ-1:0] gnt,
    output logic             vld,
    output logic [IDX_W-1:0] idx
);

    int cand;

    // Scan offsets 1..N_REQ so the last winner is considered last.
    always_comb begin
        gnt  = '0;
        vld  = 1'b0;
        idx  = '0;
        cand = 0;
        for (int k = 1; k <= N_REQ; k++) begin
            cand = (int'(ptr) + k) % N_REQ;
            if (!vld && req[cand]) begin
                vld       = 1'b1;
                gnt[cand] = 1'b1;
                idx       = IDX_W'(cand);
            end
        end
    end

endmodule

// File: rtl/accel_mem_arbiter.sv
// Round-robin arbiter sharing one memory port between N_REQ engines, with a watchdog.
// Latency: request in IDLE -> mem op 1 cycle; min 3 cycles/transaction (IDLE, WAIT, RESP).
// Backpressure: engines hold requests until their opdone pulse; memory stalls WAIT up to TIMEOUT_CYCLES.
// Ports: clk, reset (async, active-high), bus (accel_mem_arbiter_if.slave).
module accel_mem_arbiter
    import accel_mem_pkg::*;
#(
    parameter int          N_REQ          = 4,
    parameter int          TIMEOUT_CYCLES = 255,
    parameter logic [31:0] TIMEOUT_DATA   = TIMEOUT_DATA_DEFAULT
) (
    input  logic                 clk,
    input  logic                 reset,
    accel_mem_arbiter_if.slave   bus
);

    arb_state_t       state, state_nxt;
    logic [N_REQ-1:0] req_vec;
    logic [N_REQ-1:0] pick_gnt;
    logic             pick_vld;
    logic [IDX_W-1:0] pick_idx;
    logic [IDX_W-1:0] rr_ptr;     // also the index of the transaction in flight
    logic [31:0]      tmo_cnt;    // number of WAIT cycles already completed
    logic             tmo_hit;

    always_comb begin
        req_vec = '0;
        for (int r = 0; r < N_REQ; r++) begin
            req_vec[r] = is_request(bus.req_operation_i[2*r +: 2]);
        end
    end

    rr_pick #(.N_REQ(N_REQ)) u_rr_pick (
        .req (req_vec),
        .ptr (rr_ptr),
        .gnt (pick_gnt),
        .vld (pick_vld),
        .idx (pick_idx)
    );

    // Expires at the end of the TIMEOUT_CYCLES-th WAIT cycle.
    assign tmo_hit = (TIMEOUT_CYCLES != 0) && (tmo_cnt == 32'(TIMEOUT_CYCLES - 1));

    assign bus.busy_o = (state != IDLE);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (pick_vld) state_nxt = WAIT;
            WAIT:    if (bus.mem_opdone_i || tmo_hit) state_nxt = RESP;
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rr_ptr              <= IDX_W'(N_REQ - 1);
            tmo_cnt             <= '0;
            bus.grant_o         <= '0;
            bus.req_opdone_o    <= '0;
            bus.req_rdata_o     <= '0;
            bus.mem_operation_o <= MEM_OP_NONE;
            bus.mem_addr_o      <= '0;
            bus.mem_data_o      <= '0;
            bus.timeout_err_o   <= 1'b0;
            bus.timeout_id_o    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (pick_vld) begin
                        bus.grant_o         <= pick_gnt;
                        rr_ptr              <= pick_idx;
                        bus.mem_operation_o <= bus.req_operation_i[{pick_idx, 1'b0} +: 2];
                        bus.mem_addr_o      <= bus.req_addr_i[{pick_idx, 5'b0} +: 32];
                        bus.mem_data_o      <= bus.req_wdata_i[{pick_idx, 5'b0} +: 32];
                        tmo_cnt             <= '0;
                    end
                end
                WAIT: begin
                    // A real completion takes priority over a coincident expiry.
                    if (bus.mem_opdone_i) begin
                        bus.req_rdata_o     <= bus.mem_data_i;
                        bus.mem_operation_o <= MEM_OP_NONE;
                        bus.req_opdone_o    <= bus.grant_o;
                    end else if (tmo_hit) begin
                        bus.req_rdata_o     <= TIMEOUT_DATA;
                        bus.timeout_err_o   <= 1'b1;
                        bus.timeout_id_o    <= rr_ptr;
                        bus.mem_operation_o <= MEM_OP_NONE;
                        bus.req_opdone_o    <= bus.grant_o;
                    end else begin
                        tmo_cnt <= tmo_cnt + 32'd1;
                    end
                end
                RESP: begin
                    bus.req_opdone_o <= '0;
                    bus.grant_o      <= '0;
                    tmo_cnt          <= '0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_accel_mem_arbiter.sv
// Self-checking bench for accel_mem_arbiter with a queue of expected responses.
// Latency: memory model answers mem_lat cycles after an op appears; one address never answers.
// Backpressure: engine models hold each request until their opdone pulse, then present the next one.
module tb_accel_mem_arbiter;
    import accel_mem_pkg::*;

    localparam int          N    = 4;
    localparam int          TMO  = 8;
    localparam logic [31:0] MUTE = 32'hBAD0_0000;

    typedef struct {
        logic [1:0]  op;
        logic [31:0] addr;
        logic [31:0] wdata;
    } txn_t;

    typedef struct {
        int          id;
        logic [1:0]  op;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        logic        err;
        logic [2:0]  err_id;
        int          wait_cyc;
        int          gap;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;
    int   mem_lat = 1;
    logic spur_req = 1'b0;
    int   cyc = 0;
    int   last_done = 0;
    int   wait_cnt = 0;

    exp_t sb_q[$];
    txn_t eng_q[N][$];

    accel_mem_arbiter_if #(.N_REQ(N)) bus ();

    accel_mem_arbiter #(.N_REQ(N), .TIMEOUT_CYCLES(TMO), .TIMEOUT_DATA(32'hDEAD_BEEF)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_val(input logic [31:0] a);
        return a * 32'h123 + 32'h4;
    endfunction

    function automatic logic [N-1:0] oh(input int i);
        logic [N-1:0] one;
        one = 1;
        return one << i;
    endfunction

    task automatic drive(input int r, input txn_t t);
        bus.req_operation_i[2*r +: 2]  = t.op;
        bus.req_addr_i[32*r +: 32]     = t.addr;
        bus.req_wdata_i[32*r +: 32]    = t.wdata;
    endtask

    task automatic submit(input int r, input logic [1:0] op, input logic [31:0] addr, input logic [31:0] wdata);
        txn_t t;
        t.op = op; t.addr = addr; t.wdata = wdata;
        if (bus.req_operation_i[2*r +: 2] == MEM_OP_NONE && eng_q[r].size() == 0) drive(r, t);
        else eng_q[r].push_back(t);
    endtask

    task automatic push_exp(input int id, input logic [1:0] op, input logic [31:0] addr,
                            input logic [31:0] wdata, input logic [31:0] rdata, input logic err,
                            input logic [2:0] err_id, input int wait_cyc, input int gap);
        exp_t e;
        e.id = id; e.op = op; e.addr = addr; e.wdata = wdata; e.rdata = rdata;
        e.err = err; e.err_id = err_id; e.wait_cyc = wait_cyc; e.gap = gap;
        sb_q.push_back(e);
    endtask

    task automatic clear_tb_state();
        txn_t idle_t;
        idle_t.op = MEM_OP_NONE; idle_t.addr = '0; idle_t.wdata = '0;
        for (int r = 0; r < N; r++) begin
            eng_q[r].delete();
            drive(r, idle_t);
        end
        sb_q.delete();
    endtask

    task automatic do_reset();
        @(negedge clk);
        #2 reset = 1'b1;
        clear_tb_state();
        repeat (2) @(negedge clk);
        #2 reset = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int n = 0;
        while (sb_q.size() != 0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL wait_done: %0d responses outstanding after %0d cycles, required 0", sb_q.size(), budget);
            sb_q.delete();
        end
    endtask

    task automatic wait_grant(input logic [N-1:0] mask, input int budget);
        int n = 0;
        while (bus.grant_o !== mask && n < budget) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (bus.grant_o !== mask) begin
            errors++;
            $display("FAIL wait_grant: grant_o=%b after %0d cycles, required %b", bus.grant_o, budget, mask);
        end
    endtask

    // Memory model: answers mem_lat cycles after an op appears, except for MUTE.
    initial begin : mem_model
        int cnt;
        cnt = 0;
        bus.mem_opdone_i = 1'b0;
        bus.mem_data_i   = '0;
        forever begin
            @(negedge clk);
            if (bus.mem_opdone_i) begin
                bus.mem_opdone_i = 1'b0;
                cnt = 0;
            end else if (spur_req) begin
                bus.mem_opdone_i = 1'b1;
                bus.mem_data_i   = 32'h5555_AAAA;
                spur_req = 1'b0;
            end else if (!reset && bus.mem_operation_o != MEM_OP_NONE) begin
                cnt++;
                if (cnt >= mem_lat && bus.mem_addr_o != MUTE) begin
                    bus.mem_opdone_i = 1'b1;
                    bus.mem_data_i   = mem_val(bus.mem_addr_o);
                end
            end else begin
                cnt = 0;
            end
        end
    end

    // Engine models: on their opdone pulse, present the next queued request or go idle.
    initial begin : engines
        txn_t idle_t;
        idle_t.op = MEM_OP_NONE; idle_t.addr = '0; idle_t.wdata = '0;
        forever begin
            @(negedge clk);
            for (int r = 0; r < N; r++) begin
                if (!reset && bus.req_opdone_o[r] === 1'b1) begin
                    if (eng_q[r].size() > 0) drive(r, eng_q[r].pop_front());
                    else drive(r, idle_t);
                end
            end
        end
    end

    // Response monitor: checks the memory bus every WAIT cycle and each opdone pulse against the queue head.
    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (reset) begin
                wait_cnt = 0;
            end else begin
                cyc++;
                if (bus.mem_operation_o != MEM_OP_NONE) begin
                    wait_cnt++;
                    checks++;
                    if (sb_q.size() == 0) begin
                        errors++;
                        $display("FAIL wait_unexpected: mem_operation_o=%b grant_o=%b, required no transaction", bus.mem_operation_o, bus.grant_o);
                    end else begin
                        e = sb_q[0];
                        if (bus.grant_o !== oh(e.id) || bus.mem_operation_o !== e.op ||
                            bus.mem_addr_o !== e.addr || bus.mem_data_o !== e.wdata) begin
                            errors++;
                            $display("FAIL wait_bus: grant=%b op=%b addr=%h data=%h, required grant=%b op=%b addr=%h data=%h",
                                     bus.grant_o, bus.mem_operation_o, bus.mem_addr_o, bus.mem_data_o,
                                     oh(e.id), e.op, e.addr, e.wdata);
                        end
                    end
                end
                if (bus.req_opdone_o != '0) begin
                    checks++;
                    if (sb_q.size() == 0) begin
                        errors++;
                        $display("FAIL opdone_unexpected: req_opdone_o=%b, required 0", bus.req_opdone_o);
                    end else begin
                        e = sb_q.pop_front();
                        if (bus.req_opdone_o !== oh(e.id) || bus.grant_o !== oh(e.id)) begin
                            errors++;
                            $display("FAIL opdone_id: opdone=%b grant=%b, required %b", bus.req_opdone_o, bus.grant_o, oh(e.id));
                        end
                        checks++;
                        if (bus.req_rdata_o !== e.rdata) begin
                            errors++;
                            $display("FAIL opdone_rdata: req_rdata_o=%h, required %h", bus.req_rdata_o, e.rdata);
                        end
                        checks++;
                        if (bus.timeout_err_o !== e.err || (e.err && bus.timeout_id_o !== e.err_id)) begin
                            errors++;
                            $display("FAIL opdone_timeout: err=%b id=%0d, required err=%b id=%0d", bus.timeout_err_o, bus.timeout_id_o, e.err, e.err_id);
                        end
                        checks++;
                        if (wait_cnt != e.wait_cyc || bus.mem_operation_o !== MEM_OP_NONE || bus.busy_o !== 1'b1) begin
                            errors++;
                            $display("FAIL opdone_wait: wait=%0d op=%b busy=%b, required wait=%0d op=00 busy=1", wait_cnt, bus.mem_operation_o, bus.busy_o, e.wait_cyc);
                        end
                        if (e.gap != 0) begin
                            checks++;
                            if (cyc - last_done != e.gap) begin
                                errors++;
                                $display("FAIL opdone_gap: %0d cycles since previous response, required %0d", cyc - last_done, e.gap);
                            end
                        end
                    end
                    wait_cnt  = 0;
                    last_done = cyc;
                end
            end
        end
    end

    task automatic test_reset();
        reset = 1'b1;
        bus.req_operation_i = '0;
        bus.req_addr_i      = '0;
        bus.req_wdata_i     = '0;
        repeat (3) @(negedge clk);
        checks++;
        if (bus.mem_operation_o !== 2'b00 || bus.grant_o !== '0 || bus.req_opdone_o !== '0) begin
            errors++;
            $display("FAIL reset_ctrl: op=%b grant=%b opdone=%b, required all 0", bus.mem_operation_o, bus.grant_o, bus.req_opdone_o);
        end
        checks++;
        if (bus.busy_o !== 1'b0 || bus.timeout_err_o !== 1'b0 || bus.timeout_id_o !== 3'd0 || bus.req_rdata_o !== 32'd0 ||
            bus.mem_addr_o !== 32'd0 || bus.mem_data_o !== 32'd0) begin
            errors++;
            $display("FAIL reset_data: busy=%b err=%b id=%0d rdata=%h addr=%h data=%h, required all 0",
                     bus.busy_o, bus.timeout_err_o, bus.timeout_id_o, bus.req_rdata_o, bus.mem_addr_o, bus.mem_data_o);
        end
        #2 reset = 1'b0;
    endtask

    task automatic test_single_read();
        do_reset();
        mem_lat = 2;
        @(negedge clk);
        submit(0, MEM_OP_READ, 32'h10, 32'h0);
        push_exp(0, MEM_OP_READ, 32'h10, 32'h0, 32'h0000_1234, 1'b0, 3'd0, 2, 0);
        @(negedge clk);
        checks++;
        if (bus.mem_operation_o !== MEM_OP_READ || bus.grant_o !== 4'b0001) begin
            errors++;
            $display("FAIL single_latency: op=%b grant=%b one cycle after request, required 01 / 0001", bus.mem_operation_o, bus.grant_o);
        end
        wait_done(20);
        @(negedge clk);
        checks++;
        if (bus.busy_o !== 1'b0 || bus.grant_o !== '0 || bus.req_rdata_o !== 32'h0000_1234) begin
            errors++;
            $display("FAIL single_after: busy=%b grant=%b rdata=%h, required 0 / 0000 / 00001234", bus.busy_o, bus.grant_o, bus.req_rdata_o);
        end
    endtask

    task automatic test_round_robin();
        do_reset();
        mem_lat = 1;
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            for (int r = 0; r < N; r++) begin
                submit(r, MEM_OP_READ, 32'h100 + 32'(16*r + k), 32'(r));
                push_exp(r, MEM_OP_READ, 32'h100 + 32'(16*r + k), 32'(r), mem_val(32'h100 + 32'(16*r + k)),
                         1'b0, 3'd0, 1, (k == 0 && r == 0) ? 0 : 3);
            end
        end
        wait_done(100);
    endtask

    task automatic test_back_to_back();
        do_reset();
        mem_lat = 1;
        @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            submit(2, MEM_OP_WRITE, 32'h200 + 32'(k), 32'hA000_0000 + 32'(k));
            push_exp(2, MEM_OP_WRITE, 32'h200 + 32'(k), 32'hA000_0000 + 32'(k), mem_val(32'h200 + 32'(k)),
                     1'b0, 3'd0, 1, (k == 0) ? 0 : 3);
        end
        wait_done(40);
    endtask

    task automatic test_write_order();
        do_reset();
        mem_lat = 2;
        @(negedge clk);
        submit(2, MEM_OP_WRITE, 32'h40, 32'hCAFE_0001);
        submit(1, MEM_OP_READ, 32'h20, 32'h0);
        push_exp(1, MEM_OP_READ, 32'h20, 32'h0, mem_val(32'h20), 1'b0, 3'd0, 2, 0);
        push_exp(2, MEM_OP_WRITE, 32'h40, 32'hCAFE_0001, mem_val(32'h40), 1'b0, 3'd0, 2, 4);
        wait_done(40);
    endtask

    task automatic test_timeout();
        do_reset();
        mem_lat = 3;
        @(negedge clk);
        submit(2, MEM_OP_READ, MUTE, 32'h0);
        submit(3, MEM_OP_WRITE, 32'h30, 32'h0BAD_F00D);
        push_exp(2, MEM_OP_READ, MUTE, 32'h0, 32'hDEAD_BEEF, 1'b1, 3'd2, TMO, 0);
        push_exp(3, MEM_OP_WRITE, 32'h30, 32'h0BAD_F00D, mem_val(32'h30), 1'b1, 3'd2, 3, 5);
        wait_done(60);
        repeat (2) @(negedge clk);
        checks++;
        if (bus.timeout_err_o !== 1'b1 || bus.timeout_id_o !== 3'd2 || bus.busy_o !== 1'b0) begin
            errors++;
            $display("FAIL timeout_sticky: err=%b id=%0d busy=%b, required 1 / 2 / 0", bus.timeout_err_o, bus.timeout_id_o, bus.busy_o);
        end
    endtask

    task automatic test_reset_mid_wait();
        do_reset();
        mem_lat = 1;
        @(negedge clk);
        submit(1, MEM_OP_READ, MUTE, 32'h0);
        push_exp(1, MEM_OP_READ, MUTE, 32'h0, 32'h0, 1'b0, 3'd0, 0, 0);
        wait_grant(4'b0010, 10);
        @(negedge clk);
        #2 reset = 1'b1;
        #1;
        checks++;
        if (bus.mem_operation_o !== 2'b00 || bus.grant_o !== '0 || bus.req_opdone_o !== '0 || bus.busy_o !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_wait: op=%b grant=%b opdone=%b busy=%b, required all 0",
                     bus.mem_operation_o, bus.grant_o, bus.req_opdone_o, bus.busy_o);
        end
        clear_tb_state();
        repeat (2) @(negedge clk);
        #2 reset = 1'b0;
        @(negedge clk);
        submit(3, MEM_OP_READ, 32'h80, 32'h0);
        submit(0, MEM_OP_READ, 32'h90, 32'h0);
        push_exp(0, MEM_OP_READ, 32'h90, 32'h0, mem_val(32'h90), 1'b0, 3'd0, 1, 0);
        push_exp(3, MEM_OP_READ, 32'h80, 32'h0, mem_val(32'h80), 1'b0, 3'd0, 1, 3);
        wait_done(30);
    endtask

    task automatic test_spurious_and_coincident();
        do_reset();
        mem_lat = TMO;
        @(negedge clk);
        submit(1, MEM_OP_READ, 32'h50, 32'h0);
        push_exp(1, MEM_OP_READ, 32'h50, 32'h0, mem_val(32'h50), 1'b0, 3'd0, TMO, 0);
        wait_done(40);
        @(negedge clk);
        spur_req = 1'b1;
        repeat (4) @(negedge clk);
        checks++;
        if (bus.busy_o !== 1'b0 || bus.req_rdata_o !== mem_val(32'h50) || bus.timeout_err_o !== 1'b0) begin
            errors++;
            $display("FAIL spurious: busy=%b rdata=%h err=%b, required 0 / %h / 0", bus.busy_o, bus.req_rdata_o, bus.timeout_err_o, mem_val(32'h50));
        end
    endtask

    task automatic test_drop_during_wait();
        txn_t idle_t, t2;
        idle_t.op = MEM_OP_NONE; idle_t.addr = '0; idle_t.wdata = '0;
        t2.op = MEM_OP_READ; t2.addr = 32'h70; t2.wdata = '0;
        do_reset();
        mem_lat = 4;
        @(negedge clk);
        submit(1, MEM_OP_READ, 32'h60, 32'h0);
        push_exp(1, MEM_OP_READ, 32'h60, 32'h0, mem_val(32'h60), 1'b0, 3'd0, 4, 0);
        wait_grant(4'b0010, 10);
        drive(1, idle_t);
        drive(2, t2);
        @(negedge clk);
        drive(2, idle_t);
        wait_done(20);
        repeat (3) @(negedge clk);
        checks++;
        if (bus.grant_o !== '0 || bus.busy_o !== 1'b0) begin
            errors++;
            $display("FAIL drop_after: grant=%b busy=%b, required 0000 / 0", bus.grant_o, bus.busy_o);
        end
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    initial begin : main
        test_reset();
        test_single_read();
        test_round_robin();
        test_back_to_back();
        test_write_order();
        test_timeout();
        test_reset_mid_wait();
        test_spurious_and_coincident();
        test_drop_during_wait();
        repeat (2) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/accel_mem_arbiter.md
Name: accel_mem_arbiter

Overview:
- Round-robin arbiter sharing one memory port between N_REQ accelerator engines (convolution, matrix multiply, etc.).
- Each engine uses the accelerator memory protocol: mem_operation 01 = read, 11 = write, 00 = none; addr/data held until a one-cycle mem_opdone pulse.
- Sits between the engine array and the shared SRAM/Wishbone bridge.
- Provides per-transaction grant, a registered response path, and a watchdog timeout.

Parameters:
- N_REQ, 4, number of requesting engines (2..8).
- TIMEOUT_CYCLES, 255, maximum wait for mem_opdone_i; 0 disables the watchdog.
- TIMEOUT_DATA, 32'hDEAD_BEEF, read data returned to the requester on timeout.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- req_operation_i  in  2*N_REQ  per-requester mem_operation, packed, requester r at [2r+1:2r]
- req_addr_i  in  32*N_REQ  per-requester address, packed
- req_wdata_i  in  32*N_REQ  per-requester write data, packed
- req_opdone_o  out  N_REQ  one-cycle completion pulse to the granted requester
- req_rdata_o  out  32  response data, shared by all requesters, valid while req_opdone_o is high
- grant_o  out  N_REQ  one-hot owner of the current transaction
- mem_operation_o  out  2  to memory
- mem_addr_o  out  32  to memory
- mem_data_o  out  32  to memory
- mem_opdone_i  in  1  memory completion pulse
- mem_data_i  in  32  memory read data, valid with mem_opdone_i
- busy_o  out  1  high in any state other than IDLE
- timeout_err_o  out  1  sticky; set on a watchdog expiry
- timeout_id_o  out  3  requester index of the most recent timeout

Behaviour:
- Reset (asynchronous): all outputs 0; mem_operation_o = 00 immediately; state IDLE; rr_ptr = N_REQ-1, so requester 0 wins the first arbitration; timeout counter 0.
- A requester is "requesting" when its operation is 01 or 11. Operation 10 is treated as no request.
- IDLE:
  - If any requester is requesting, pick the first one found searching from rr_ptr+1 upward, with wrap-around.
  - Register grant_o one-hot, rr_ptr = winner, and the winner's addr, wdata and operation onto mem_*_o. Go to WAIT.
  - Latency from request seen in IDLE to mem_operation_o asserted: 1 cycle.
- WAIT:
  - mem_*_o and grant_o are held stable; the timeout counter increments each cycle.
  - On mem_opdone_i: capture mem_data_i into req_rdata_o, drive mem_operation_o = 00, go to RESP.
  - On counter reaching TIMEOUT_CYCLES with no mem_opdone_i: req_rdata_o = TIMEOUT_DATA; set timeout_err_o and timeout_id_o; mem_operation_o = 00; go to RESP.
  - If mem_opdone_i and timeout occur in the same cycle, mem_opdone_i wins and no error is flagged.
- RESP:
  - req_opdone_o[winner] = 1 for exactly one cycle; grant_o is still held.
  - Next state IDLE; grant_o cleared; timeout counter cleared.
  - The engine updates its addr/operation on this edge, so IDLE always re-arbitrates on fresh values and no stale request is reissued.
- Throughput:
  - Minimum 3 cycles per transaction (IDLE, WAIT, RESP) when memory answers in the first WAIT cycle.
  - A requester holding its request continuously (burst parameter fetch) gets at most one transaction per round while others are requesting.
- Boundary cases:
  - mem_opdone_i in IDLE or RESP is ignored.
  - A requester dropping its request during WAIT does not abort the transaction; the response is still pulsed.
  - A requester whose request disappears before IDLE samples it is simply not granted.
  - A single active requester is re-granted back-to-back every 3 cycles.
  - Reset asserted mid-WAIT aborts the memory cycle at once with no opdone pulse; memory must tolerate the dropped operation.
- req_rdata_o holds its value outside RESP. It is also updated on writes, with whatever mem_data_i carries at opdone.
- timeout_err_o clears only on reset.

Decomposition:
- Package accel_mem_pkg holds:
  - MEM_OP_NONE = 2'b00, MEM_OP_READ = 2'b01, MEM_OP_WRITE = 2'b11
  - the arbiter state encoding (IDLE / WAIT / RESP)
  - the default TIMEOUT_DATA
  - a helper function is_request(op)
- One sub-module, rr_pick: a combinational round-robin selector. Inputs are the N_REQ request vector and rr_ptr; outputs are one-hot grant, a valid flag, and the binary index. Instantiated once.

Test Plan:
- Single requester 0 reads addr 0x10, memory returns 0x1234 two cycles after issue -> mem_operation_o = 01 one cycle after request; req_opdone_o = 4'b0001 for one cycle with req_rdata_o = 0x1234; busy_o low afterwards.
- Requesters 0-3 request simultaneously and hold their requests -> grant order 0,1,2,3,0; each gets exactly one opdone per round; mem_addr_o matches the granted requester every cycle of WAIT.
- Requester 2 writes 0xCAFE0001 to 0x40 while requester 1 reads -> requester 1 served first, then requester 2; mem_data_o = 0xCAFE0001 with mem_operation_o = 11 during requester 2's WAIT.
- Memory never answers, TIMEOUT_CYCLES = 8 -> after 8 WAIT cycles, req_opdone_o pulses with req_rdata_o = 0xDEADBEEF; timeout_err_o = 1 and timeout_id_o = granted index; the next requester is then served normally.
- Reset asserted in the middle of WAIT -> mem_operation_o = 00 and grant_o = 0 immediately, with no req_opdone_o pulse; after reset release, requester 0 wins first.
- Spurious mem_opdone_i in IDLE, and mem_opdone_i coinciding with timeout expiry -> no response pulse for the spurious one; the coincident one is completed normally with timeout_err_o remaining 0.
